// File: rtl/tail_light_sequencer.sv
// Thunderbird-style tail-light controller with a built-in step-rate divider.
// Turn requests light each side's lamps in a fill-outward run; hazard
// flashes both sides together; brake lights any side that is not sequencing
// or flashing. Lamp outputs are registered and drive the LEDs directly.
module tail_light_sequencer #(
    parameter int LAMPS = 3,
    parameter int DIV   = 50_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             left,
    input  logic             right,
    input  logic             hazard,
    input  logic             brake,
    output logic [LAMPS-1:0] l_lamps,
    output logic [LAMPS-1:0] r_lamps,
    output logic             step
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PW = $clog2(LAMPS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [PW-1:0] POS_MAX = PW'(LAMPS);

    typedef enum logic [1:0] {IDLE, LSEQ, RSEQ, HAZ} state_t;

    state_t            state_reg, state_next;
    logic [PW-1:0]     pos_reg, pos_next;
    logic              phase_reg, phase_next;
    logic [CW-1:0]     cnt_reg;
    logic              tick;
    logic              haz_req;
    logic              decide;
    logic [LAMPS-1:0]  pattern;
    logic [LAMPS-1:0]  brake_mask;
    logic [LAMPS-1:0]  l_next, r_next;

    assign tick       = (cnt_reg == CNT_MAX);
    assign step       = tick;
    assign haz_req    = hazard | (left & right);
    assign brake_mask = {LAMPS{brake}};

    // Free-running step divider; wraps every DIV cycles regardless of state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt_reg <= '0;
        else if (tick)
            cnt_reg <= '0;
        else
            cnt_reg <= cnt_reg + 1'b1;
    end

    // State, run position and hazard phase register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            pos_reg   <= '0;
            phase_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pos_reg   <= pos_next;
            phase_reg <= phase_next;
        end
    end

    // Next-state logic; everything moves only on a tick, requests are
    // re-evaluated only at the end of a run, flash cycle or while idle.
    always_comb begin
        state_next = state_reg;
        pos_next   = pos_reg;
        phase_next = phase_reg;
        decide     = 1'b0;
        if (tick) begin
            case (state_reg)
                IDLE: decide = 1'b1;
                LSEQ, RSEQ: begin
                    if (pos_reg == '0) begin
                        decide = 1'b1;
                    end else if (haz_req) begin
                        // hazard overrides a turn run that is still lit
                        state_next = HAZ;
                        phase_next = 1'b1;
                        pos_next   = '0;
                    end else if (pos_reg == POS_MAX) begin
                        pos_next = '0;
                    end else begin
                        pos_next = pos_reg + 1'b1;
                    end
                end
                HAZ: begin
                    if (!phase_reg)
                        decide = 1'b1;
                    else
                        phase_next = 1'b0;
                end
                default: decide = 1'b1;
            endcase
            if (decide) begin
                pos_next   = '0;
                phase_next = 1'b0;
                if (haz_req) begin
                    state_next = HAZ;
                    phase_next = 1'b1;
                end else if (left) begin
                    state_next = LSEQ;
                    pos_next   = PW'(1);
                end else if (right) begin
                    state_next = RSEQ;
                    pos_next   = PW'(1);
                end else begin
                    state_next = IDLE;
                end
            end
        end
    end

    // Fill-outward run pattern: lamp gi is lit once the run has passed it.
    genvar gi;
    generate
        for (gi = 0; gi < LAMPS; gi++) begin : g_pattern
            assign pattern[gi] = (int'(pos_next) > gi);
        end
    endgenerate

    // Lamp decode from the next state; brake fills any non-sequencing side.
    always_comb begin
        l_next = brake_mask;
        r_next = brake_mask;
        case (state_next)
            LSEQ: l_next = pattern;
            RSEQ: r_next = pattern;
            HAZ: begin
                l_next = {LAMPS{phase_next}};
                r_next = {LAMPS{phase_next}};
            end
            default: ;
        endcase
    end

    // Registered lamp drivers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            l_lamps <= '0;
            r_lamps <= '0;
        end else begin
            l_lamps <= l_next;
            r_lamps <= r_next;
        end
    end

endmodule

// File: tb/tb_tail_light_sequencer.sv
// Bench for tail_light_sequencer: directed scenarios plus randomized traffic
// checked against a frame-list model of the lamp behaviour.
module tb_tail_light_sequencer;

    localparam int LAMPS = 3;
    localparam int DIV   = 4;
    localparam logic [LAMPS-1:0] ALL = LAMPS'((1 << LAMPS) - 1);

    logic             clk = 1'b0;
    logic             reset, left, right, hazard, brake;
    logic [LAMPS-1:0] l_lamps, r_lamps;
    logic             step;

    int tests_run = 0;
    int failed    = 0;

    tail_light_sequencer #(.LAMPS(LAMPS), .DIV(DIV)) dut (
        .clk(clk), .reset(reset), .left(left), .right(right),
        .hazard(hazard), .brake(brake),
        .l_lamps(l_lamps), .r_lamps(r_lamps), .step(step)
    );

    always #5 clk = ~clk;

    // Model: the upcoming display frames of the current activity. The head is
    // what is shown now; a single remaining frame means the activity is done
    // and the next tick picks a new one from the requests.
    // kind: 0 idle, 1 left run, 2 right run, 3 hazard flash.
    typedef struct {
        int               kind;
        logic [LAMPS-1:0] pat;
    } frame_t;

    frame_t           q[$];
    int               m_cnt;
    bit               m_ticked;
    logic [LAMPS-1:0] exp_l, exp_r;
    logic             exp_step;

    task automatic model_reset();
        q.delete();
        q.push_back('{0, '0});
        m_cnt    = 0;
        m_ticked = 0;
        exp_l    = '0;
        exp_r    = '0;
        exp_step = 1'b0;
    endtask

    task automatic model_decide(bit h, bit l, bit r);
        q.delete();
        if (h || (l && r)) begin
            q.push_back('{3, ALL});
            q.push_back('{3, '0});
        end else if (l || r) begin
            for (int k = 1; k <= LAMPS; k++)
                q.push_back('{l ? 1 : 2, LAMPS'((1 << k) - 1)});
            q.push_back('{l ? 1 : 2, '0});
        end else begin
            q.push_back('{0, '0});
        end
    endtask

    // One clock edge for both DUT and model; returns 1 ns after the edge.
    task automatic advance();
        bit h, l, r, b, t;
        h = hazard; l = left; r = right; b = brake;
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else begin
            t     = (m_cnt == DIV - 1);
            m_cnt = t ? 0 : m_cnt + 1;
            if (t) begin
                if (q.size() == 1)
                    model_decide(h, l, r);
                else if ((q[0].kind == 1 || q[0].kind == 2) && (h || (l && r)))
                    model_decide(1'b1, 1'b0, 1'b0);
                else
                    void'(q.pop_front());
            end
            exp_l = b ? ALL : '0;
            exp_r = b ? ALL : '0;
            case (q[0].kind)
                1: exp_l = q[0].pat;
                2: exp_r = q[0].pat;
                3: begin exp_l = q[0].pat; exp_r = q[0].pat; end
                default: ;
            endcase
            exp_step = (m_cnt == DIV - 1);
            m_ticked = t;
        end
        #1;
    endtask

    task automatic advance_to_tick();
        for (int i = 0; i <= DIV; i++) begin
            advance();
            if (m_ticked) break;
        end
    endtask

    task automatic drain();
        left = 0; right = 0; hazard = 0; brake = 0;
        for (int i = 0; i < 2 * (LAMPS + 3); i++) begin
            advance_to_tick();
            if (q.size() == 1 && q[0].kind == 0) break;
        end
    endtask

    task automatic test_reset();
        logic exp_s [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        reset = 0;
        left = 1'($urandom_range(0, 1)); right = 1'($urandom_range(0, 1));
        hazard = 1'($urandom_range(0, 1)); brake = 1'($urandom_range(0, 1));
        for (int i = 0; i < 3; i++) advance();
        tests_run++;
        if (l_lamps !== '0 || r_lamps !== '0 || step !== 1'b0) begin
            failed++;
            $display("FAIL reset_hold: l=%b r=%b step=%b, expected 000 000 0", l_lamps, r_lamps, step);
        end
        left = 0; right = 0; hazard = 0; brake = 0;
        reset = 1;
        for (int i = 0; i < 4; i++) begin
            advance();
            tests_run++;
            if (step !== exp_s[i] || l_lamps !== '0 || r_lamps !== '0) begin
                failed++;
                $display("FAIL reset_release[%0d]: step=%b l=%b r=%b, expected step=%b l=000 r=000",
                         i, step, l_lamps, r_lamps, exp_s[i]);
            end
        end
    endtask

    task automatic test_turn_held();
        logic [LAMPS-1:0] seq [5] = '{3'b001, 3'b011, 3'b111, 3'b000, 3'b001};
        for (int side = 0; side < 2; side++) begin
            drain();
            left = (side == 0); right = (side == 1);
            for (int k = 0; k < 5; k++) begin
                advance_to_tick();
                tests_run++;
                if ((side == 0 && (l_lamps !== seq[k] || r_lamps !== '0)) ||
                    (side == 1 && (r_lamps !== seq[k] || l_lamps !== '0))) begin
                    failed++;
                    $display("FAIL turn_held side=%0d step %0d: l=%b r=%b, run side expected %b, other 000",
                             side, k, l_lamps, r_lamps, seq[k]);
                end
            end
        end
    endtask

    task automatic test_release_and_both();
        logic [LAMPS-1:0] rel [4] = '{3'b011, 3'b111, 3'b000, 3'b000};
        logic [LAMPS-1:0] both [3] = '{3'b111, 3'b000, 3'b111};
        drain();
        left = 1;
        advance_to_tick();
        left = 0;
        for (int k = 0; k < 4; k++) begin
            advance_to_tick();
            tests_run++;
            if (l_lamps !== rel[k] || r_lamps !== '0) begin
                failed++;
                $display("FAIL left_release step %0d: l=%b r=%b, expected l=%b r=000", k, l_lamps, r_lamps, rel[k]);
            end
        end
        left = 1; right = 1;
        for (int k = 0; k < 3; k++) begin
            advance_to_tick();
            tests_run++;
            if (l_lamps !== both[k] || r_lamps !== both[k]) begin
                failed++;
                $display("FAIL left_right_both step %0d: l=%b r=%b, expected both %b", k, l_lamps, r_lamps, both[k]);
            end
        end
    endtask

    task automatic test_hazard();
        logic [LAMPS-1:0] hl [5] = '{3'b111, 3'b000, 3'b111, 3'b000, 3'b001};
        logic [LAMPS-1:0] hr [5] = '{3'b111, 3'b000, 3'b111, 3'b000, 3'b000};
        drain();
        left = 1;
        advance_to_tick();
        advance_to_tick();
        hazard = 1;
        for (int k = 0; k < 5; k++) begin
            if (k == 3) hazard = 0;
            advance_to_tick();
            tests_run++;
            if (l_lamps !== hl[k] || r_lamps !== hr[k]) begin
                failed++;
                $display("FAIL hazard step %0d: l=%b r=%b, expected l=%b r=%b", k, l_lamps, r_lamps, hl[k], hr[k]);
            end
        end
    endtask

    task automatic test_brake();
        logic [LAMPS-1:0] rs [3] = '{3'b011, 3'b111, 3'b000};
        drain();
        right = 1;
        advance_to_tick();
        brake = 1;
        advance();
        tests_run++;
        if (l_lamps !== ALL || r_lamps !== 3'b001) begin
            failed++;
            $display("FAIL brake_rseq_latency: l=%b r=%b, expected l=111 r=001", l_lamps, r_lamps);
        end
        for (int k = 0; k < 3; k++) begin
            if (k == 2) right = 0;
            advance_to_tick();
            tests_run++;
            if (l_lamps !== ALL || r_lamps !== rs[k]) begin
                failed++;
                $display("FAIL brake_rseq step %0d: l=%b r=%b, expected l=111 r=%b", k, l_lamps, r_lamps, rs[k]);
            end
        end
        advance_to_tick();
        brake = 0;
        advance();
        tests_run++;
        if (l_lamps !== '0 || r_lamps !== '0) begin
            failed++;
            $display("FAIL brake_release_idle: l=%b r=%b, expected 000 000", l_lamps, r_lamps);
        end
        brake = 1;
        advance();
        tests_run++;
        if (l_lamps !== ALL || r_lamps !== ALL) begin
            failed++;
            $display("FAIL brake_idle: l=%b r=%b, expected 111 111", l_lamps, r_lamps);
        end
        hazard = 1;
        advance_to_tick();
        advance_to_tick();
        tests_run++;
        if (l_lamps !== '0 || r_lamps !== '0) begin
            failed++;
            $display("FAIL brake_in_hazard: l=%b r=%b, expected 000 000", l_lamps, r_lamps);
        end
        hazard = 0; brake = 0;
    endtask

    task automatic test_async_reset();
        for (int pass = 0; pass < 2; pass++) begin
            drain();
            left = 1;
            advance_to_tick();
            advance_to_tick();
            #3 reset = 0;
            #1;
            tests_run++;
            if (l_lamps !== '0 || r_lamps !== '0 || step !== 1'b0) begin
                failed++;
                $display("FAIL async_reset pass %0d: l=%b r=%b step=%b, expected 000 000 0",
                         pass, l_lamps, r_lamps, step);
            end
            model_reset();
            left = (pass == 1);
            advance();
            reset = 1;
            advance_to_tick();
            tests_run++;
            if (l_lamps !== ((pass == 1) ? 3'b001 : 3'b000) || r_lamps !== '0) begin
                failed++;
                $display("FAIL restart_after_reset pass %0d: l=%b r=%b, expected l=%b r=000",
                         pass, l_lamps, r_lamps, (pass == 1) ? 3'b001 : 3'b000);
            end
        end
    endtask

    task automatic test_random();
        drain();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                left   = 1'($urandom_range(0, 1));
                right  = 1'($urandom_range(0, 1));
                hazard = ($urandom_range(0, 3) == 0);
            end
            if ($urandom_range(0, 7) == 0) brake = ~brake;
            reset = ($urandom_range(0, 99) != 0);
            advance();
            tests_run++;
            if (l_lamps !== exp_l || r_lamps !== exp_r || step !== exp_step) begin
                failed++;
                $display("FAIL random cycle %0d: l=%b r=%b step=%b, expected l=%b r=%b step=%b",
                         i, l_lamps, r_lamps, step, exp_l, exp_r, exp_step);
            end
        end
        reset = 1;
    endtask

    initial begin
        reset = 0; left = 0; right = 0; hazard = 0; brake = 0;
        model_reset();
        test_reset();
        test_turn_held();
        test_release_and_both();
        test_hazard();
        test_brake();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/tail_light_sequencer.md
# tail_light_sequencer

Parametrised Thunderbird-style tail-light controller: drives LAMPS lamps per side with sequential turn indication, hazard flashing and brake override. It contains its own step-rate divider, so it connects directly to the board clock and replaces the separate light FSM and clock-scaler pair in the top level. Lamp outputs are registered and drive the LEDs directly.

## Interface
- LAMPS, 3: lamps per side, 2..8; bit 0 is the innermost lamp.
- DIV, 50_000_000: clk cycles per sequence step, ≥2.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low (0 = reset).
- left  in  1  left turn request, level.
- right  in  1  right turn request, level.
- hazard  in  1  hazard request, level.
- brake  in  1  brake request, level.
- l_lamps  out  LAMPS  left lamps, 1 = lit.
- r_lamps  out  LAMPS  right lamps, 1 = lit.
- step  out  1  high for the one clk cycle before each step edge (debug/bench sync).

## Operation
- Divider: cnt counts 0..DIV-1 and wraps; width $clog2(DIV). tick = (cnt == DIV-1); step = tick. It runs continuously regardless of state.
- State machine: IDLE, LSEQ, RSEQ, HAZ. Registers pos (0..LAMPS, width $clog2(LAMPS+1)) and phase (1 bit). All transitions occur only on a tick edge.
- Request priority at a decision point:
  - hazard, or left and right together → HAZ with phase=1.
  - else left → LSEQ with pos=1.
  - else right → RSEQ with pos=1.
  - else → IDLE.
- Decision points:
  - every tick in IDLE;
  - tick in LSEQ/RSEQ with pos==0;
  - tick in HAZ with phase==0.
- LSEQ/RSEQ with pos in 1..LAMPS-1: tick sets pos+1. With pos==LAMPS: tick sets pos=0 (off step). Releasing the turn request does not abort a run; the run completes through pos 0.
- Hazard abort: if hazard (or left and right together) is high on a tick while LSEQ/RSEQ has pos≠0, go to HAZ with phase=1 immediately.
- HAZ with phase==1: tick sets phase=0, unconditionally.
- Sequencing-side pattern is fill-outward: the low pos bits are set, i.e. (1<<pos)-1, so pos=0 gives all off and pos=LAMPS gives all on.
- Lamp outputs, computed from the next state and registered on every clk edge:
  - LSEQ: l_lamps = pattern; r_lamps = brake ? all 1 : 0.
  - RSEQ: mirror of LSEQ.
  - HAZ: both sides = phase ? all 1 : 0. Brake is ignored.
  - IDLE: both sides = brake ? all 1 : 0.

## Timing
- Reset (reset=0), asynchronous: cnt=0, IDLE, pos=0, phase=0, l_lamps=0, r_lamps=0, step=0. Outputs clear without a clk edge.
- After reset is released, the first tick occurs in cycle DIV-1, so the first state change happens on the DIV-th rising edge.
- Request inputs are sampled only on the tick edge. A request pulse that falls entirely between ticks is ignored.
- State, pos, phase and lamps update on the same tick edge. Lamp latency from that tick edge is 0 cycles.
- Brake is sampled on every edge. The lamp change appears at the first rising edge after brake changes (1-cycle latency), independent of tick.
- Step period is DIV clks. A full turn run lasts LAMPS+1 steps.
- Reset asserted mid-run aborts immediately with no completion of the sequence. The divider restarts from 0.

## Test plan
Bench parameters: LAMPS=3, DIV=4.
- Reset: hold reset=0 with other inputs random → l_lamps=r_lamps=000, step=0. Release → step first high in cycle 3.
- Left held: successive tick edges give l_lamps 001, 011, 111, 000, 001 … while r_lamps stays 000. With right held instead, the mirror result on r_lamps.
- Left released right after entering pos=1 → l_lamps continues 011, 111, 000, then stays 000 in IDLE. Left and right together from IDLE → both sides 111, 000, 111 …
- Hazard raised while LSEQ pos=2 → next tick both sides 111, then 000, 111. Hazard dropped with left high → after the current 111 step comes 000, then l_lamps 001.
- Brake during RSEQ → l_lamps=111 one clk after assertion, while r_lamps keeps sequencing unaffected. Brake in IDLE → both sides 111. Brake in HAZ → no effect.
- Reset pulsed low asynchronously mid-clock during LSEQ pos=2 → lamps 000 before the next edge. After release, sequencing restarts only if left is high at the first tick.
